lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store unit sitting between the core's execute/memory stage and the word-addressed data memory. It accepts one RV32 load or store request per handshake and drives the memory's address, write-data and write-enable. Memory read data is combinational and writes are word-wide on the clock edge. Byte and halfword accesses are built on top of that: sub-word loads are extracted and sign/zero-extended, and sub-word stores are done as a read-modify-write.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle; it can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32 width code:
  - loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - stores: 000 sb, 001 sh, 010 sw.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the low byte/halfword is used for sb/sh.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_rdata`  out  32  load result; 0 for stores and faults.
- `resp_fault`  out  1  qualifies `resp_valid`; the access was rejected.
- `mem_addr`  out  32  word address to memory; bits [1:0] always 00.
- `mem_wdata`  out  32  write word to memory.
- `mem_we`  out  1  memory write enable.
- `mem_rdata`  in  32  combinational read data for `mem_addr`.

## Operation
- FSM states and transitions:
  - IDLE: on `req_valid && req_ready`, latch we/funct3/addr/wdata. Go to RESP if the request faults, else ACCESS.
  - ACCESS: drive the latched word address.
    - load: capture the extracted `mem_rdata` into `resp_rdata`; go to RESP.
    - sw: assert `mem_we` with `mem_wdata` = latched wdata; go to RESP.
    - sb/sh: capture `mem_rdata` as the old word; go to WRITE.
  - WRITE (sb/sh only): assert `mem_we` with the merged word; go to RESP.
  - RESP: `resp_valid`=1 for this single cycle; go to IDLE.
- `req_ready` is 1 only in IDLE and only while `rst_n`=1. No request is accepted in RESP.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by addr[1:0]. The halfword is selected by addr[1].
- Load extension:
  - lb/lh sign-extend from bit 7/15.
  - lbu/lhu zero-extend.
  - lw passes the word through.
- Store merge: only the addressed lane(s) are replaced with `req_wdata[7:0]` or `req_wdata[15:0]`; all other bytes keep their old value.
- Illegal funct3 always faults, with no memory access:
  - load: 011, 110, 111.
  - store: any code other than 000/001/010.
- `mem_addr` is `{addr[31:2],2'b00}` in ACCESS/WRITE and 0 otherwise.
- `mem_wdata` is 0 whenever `mem_we`=0.
- `mem_we` is 1 only in the sw ACCESS cycle or the WRITE cycle. It is gated by `rst_n`: 0 in any cycle where `rst_n`=0.
- `resp_rdata` and `resp_fault` hold their last values until the next RESP updates them.

## Timing
- E0 is the edge where the request is accepted.
- Response cycles:
  - load and sw: ACCESS is E0–E1 and `resp_valid` is high E1–E2 (2 cycles to response).
  - sb/sh: ACCESS E0–E1, WRITE E1–E2 with `mem_we`=1, `resp_valid` E2–E3 (3 cycles).
  - fault: `resp_valid`=1 and `resp_fault`=1 during E0–E1 (1 cycle); `mem_we` is never asserted.
- Back-to-back: a new request is accepted at the edge ending RESP+1, i.e. the first IDLE cycle.
- Reset (rst_n=0 at any edge):
  - state goes to IDLE.
  - `resp_valid`=0, `resp_rdata`=0, `resp_fault`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `req_ready`=0 while reset is asserted and 1 in the first cycle after deassertion.
  - Reset during ACCESS/WRITE aborts the operation; no write reaches memory after the reset edge.
- `req_*` inputs are sampled only at E0; later changes are ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - lh/lhu/sh with addr[0]≠0, or lw/sw with addr[1:0]≠00, fault.
  - Fault path: IDLE→RESP, `resp_fault`=1, `resp_rdata`=0, no memory cycle.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - no alignment check.
  - halfword accesses ignore addr[0]; word accesses ignore addr[1:0].
  - `resp_fault` is raised only for illegal funct3.

## Test plan
- Preload word 0x10 = 0x8081_7F02 and run four loads:
  - lb 0x12 → 0xFFFF_FF81.
  - lbu 0x12 → 0x0000_0081.
  - lh 0x12 → 0xFFFF_8081.
  - lhu 0x10 → 0x0000_7F02.
  - Each load gives `resp_valid` 2 cycles after accept and `mem_we` never high.
- sb 0x13, wdata 0x1234_56AA → word 0x10 = 0xAA81_7F02. `mem_we` is high for exactly one cycle and `resp_valid` comes 3 cycles after accept.
- sh 0x10, wdata 0x1234_5678 → word 0x10 = 0x8081_5678. Then sw 0x14, wdata 0xDEAD_BEEF → word 0x14 = 0xDEAD_BEEF with response at 2 cycles.
- lw 0x12:
  - with `LSU_MISALIGN_TRAP_EN` → `resp_fault`=1 one cycle after accept, no memory cycle.
  - without it → `resp_rdata` = the word at 0x10, `resp_fault`=0.
- Load with funct3=011 (either build) → `resp_fault`=1 and `resp_rdata`=0 one cycle after accept; `mem_we` stays 0.
- Start sb 0x10, drive `rst_n`=0 at the ACCESS→WRITE edge → memory word unchanged and all outputs 0. After `rst_n`=1, `req_ready`=1 and the next lw completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl
// Load/store unit between the core's execute/memory stage and a word-addressed
// data memory with combinational read data and word-wide clocked writes.
// Byte/halfword loads are extracted and sign/zero-extended; byte/halfword
// stores are done as a read-modify-write (ACCESS reads old word, WRITE stores
// the merged word).
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned lh/lhu/sh (addr[0]=1) and lw/sw (addr[1:0]!=0) fault
//   undefined : no alignment check; halfword ignores addr[0], word ignores addr[1:0]
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/ready   request handshake (ready only in IDLE, out of reset)
//   req_we            1 = store, 0 = load
//   req_funct3        RV32 width code
//   req_addr          byte address
//   req_wdata         store data (low byte/halfword for sb/sh)
//   resp_valid        one-cycle response strobe
//   resp_rdata        load result (0 for stores and faults), held until next response
//   resp_fault        access rejected, held until next response
//   mem_addr          word address to memory (0 when idle)
//   mem_wdata         write word (0 when mem_we=0)
//   mem_we            memory write enable
//   mem_rdata         combinational read data for mem_addr
module lsu_mem_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state_r;
  state_t      state_next_s;
  logic        we_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] merged_r;
  logic [31:0] resp_rdata_r;
  logic        resp_fault_r;
  logic        accept_s;
  logic        req_fault_s;
  logic        is_sw_s;

  // Decide whether a request is rejected without touching memory.
  function automatic logic access_faults(input logic we, input logic [2:0] f3,
                                         input logic [1:0] lo);
    logic bad_v;
    bad_v = 1'b0;
    if (we) begin
      case (f3)
        F3_B, F3_H, F3_W: bad_v = 1'b0;
        default:          bad_v = 1'b1;
      endcase
    end else begin
      case (f3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: bad_v = 1'b0;
        default:                        bad_v = 1'b1;
      endcase
    end
`ifdef LSU_MISALIGN_TRAP_EN
    case (f3)
      F3_H, F3_HU: if (lo[0] != 1'b0) bad_v = 1'b1;
      F3_W:        if (lo != 2'b00) bad_v = 1'b1;
      default:     bad_v = bad_v;
    endcase
`else
    bad_v = bad_v | (lo[0] & 1'b0);
`endif
    return bad_v;
  endfunction

  // Extract and extend the addressed byte/halfword of a load.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] word);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (lo)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    res_v = {{24{byte_v[7]}}, byte_v};
      F3_H:    res_v = {{16{half_v[15]}}, half_v};
      F3_W:    res_v = word;
      F3_BU:   res_v = {24'h000000, byte_v};
      F3_HU:   res_v = {16'h0000, half_v};
      default: res_v = 32'h0000_0000;
    endcase
    return res_v;
  endfunction

  // Replace only the addressed lane(s) of the old word with the store data.
  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] old_word,
                                              input logic [31:0] wdata);
    logic [31:0] res_v;
    res_v = old_word;
    case (f3)
      F3_B: begin
        case (lo)
          2'd0:    res_v[7:0]   = wdata[7:0];
          2'd1:    res_v[15:8]  = wdata[7:0];
          2'd2:    res_v[23:16] = wdata[7:0];
          default: res_v[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (lo[1]) begin
          res_v[31:16] = wdata[15:0];
        end else begin
          res_v[15:0] = wdata[15:0];
        end
      end
      default: res_v = wdata;
    endcase
    return res_v;
  endfunction

  assign accept_s    = req_valid && req_ready;
  assign req_fault_s = access_faults(req_we, req_funct3, req_addr[1:0]);
  assign is_sw_s     = we_r && (funct3_r == F3_W);

  // Handshake and response strobe decode from the state register.
  always_comb begin
    req_ready  = rst_n && (state_r == ST_IDLE);
    resp_valid = rst_n && (state_r == ST_RESP);
    resp_rdata = resp_rdata_r;
    resp_fault = resp_fault_r;
  end

  // Memory-side drive; write enable is forced low whenever reset is asserted.
  always_comb begin
    mem_addr  = 32'h0000_0000;
    mem_we    = 1'b0;
    mem_wdata = 32'h0000_0000;
    if (rst_n && ((state_r == ST_ACCESS) || (state_r == ST_WRITE))) begin
      mem_addr = {addr_r[31:2], 2'b00};
      if (state_r == ST_WRITE) begin
        mem_we    = 1'b1;
        mem_wdata = merged_r;
      end else if (is_sw_s) begin
        mem_we    = 1'b1;
        mem_wdata = wdata_r;
      end else begin
        mem_we    = 1'b0;
      end
    end else begin
      mem_addr = 32'h0000_0000;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = req_fault_s ? ST_RESP : ST_ACCESS;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!we_r || is_sw_s) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_WRITE;
        end
      end
      ST_WRITE: state_next_s = ST_RESP;
      ST_RESP:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State register, request latch and response/merge registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      we_r         <= 1'b0;
      funct3_r     <= 3'b000;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      merged_r     <= 32'h0000_0000;
      resp_rdata_r <= 32'h0000_0000;
      resp_fault_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            we_r     <= req_we;
            funct3_r <= req_funct3;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
            if (req_fault_s) begin
              resp_rdata_r <= 32'h0000_0000;
              resp_fault_r <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          if (!we_r) begin
            resp_rdata_r <= load_extract(funct3_r, addr_r[1:0], mem_rdata);
            resp_fault_r <= 1'b0;
          end else if (is_sw_s) begin
            resp_rdata_r <= 32'h0000_0000;
            resp_fault_r <= 1'b0;
          end else begin
            merged_r <= store_merge(funct3_r, addr_r[1:0], mem_rdata, wdata_r);
          end
        end
        ST_WRITE: begin
          resp_rdata_r <= 32'h0000_0000;
          resp_fault_r <= 1'b0;
        end
        default: begin
          resp_rdata_r <= resp_rdata_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int errors;
  int checks;

  logic [31:0] tb_mem [0:15];
  logic        pre_en;
  logic [3:0]  pre_idx;
  logic [31:0] pre_data;

  lsu_mem_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = tb_mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (pre_en) tb_mem[pre_idx] <= pre_data;
    else if (mem_we) tb_mem[mem_addr[5:2]] <= mem_wdata;
  end

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_data = data;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Issue one request in the first IDLE cycle, scramble req_* after accept,
  // and watch until the response strobe (bounded).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic fault, output int lat, output int we_cycles);
    logic got;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_req: got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    got = 1'b0; lat = 0; we_cycles = 0; rdata = 32'h0; fault = 1'b0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
        req_addr = 32'hFFFF_FFFC; req_wdata = 32'h0;
      end
      if (mem_we === 1'b1) we_cycles++;
      if (resp_valid === 1'b1) begin
        got = 1'b1; lat = i; rdata = resp_rdata; fault = resp_fault;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL resp_timeout: no resp_valid within 10 cycles");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b valid=%b we=%b want 0 0 0", req_ready, resp_valid, mem_we);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0 || resp_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h fault=%b want zeros",
               mem_addr, mem_wdata, resp_rdata, resp_fault);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b want 1", req_ready);
    end
  endtask

  task automatic test_loads();
    logic [31:0] rd; logic ft; int lat; int wc;
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ads [4] = '{32'h12, 32'h12, 32'h12, 32'h10};
    logic [31:0] exp [4] = '{32'hFFFF_FF81, 32'h0000_0081, 32'hFFFF_8081, 32'h0000_7F02};
    preload(4'd4, 32'h8081_7F02);
    for (int k = 0; k < 4; k++) begin
      do_req(1'b0, f3s[k], ads[k], 32'h0, rd, ft, lat, wc);
      checks++;
      if (rd !== exp[k] || ft !== 1'b0) begin
        errors++;
        $display("FAIL load%0d_data: got %h/%b want %h/0", k, rd, ft, exp[k]);
      end
      checks++;
      if (lat != 2 || wc != 0) begin
        errors++;
        $display("FAIL load%0d_timing: lat=%0d we_cycles=%0d want 2 0", k, lat, wc);
      end
    end
  endtask

  task automatic test_stores();
    logic [31:0] rd; logic ft; int lat; int wc;
    do_req(1'b1, 3'b000, 32'h13, 32'h1234_56AA, rd, ft, lat, wc);
    checks++;
    if (tb_mem[4] !== 32'hAA81_7F02) begin
      errors++;
      $display("FAIL sb_mem: got %h want aa817f02", tb_mem[4]);
    end
    checks++;
    if (lat != 3 || wc != 1 || rd !== 32'h0 || ft !== 1'b0) begin
      errors++;
      $display("FAIL sb_resp: lat=%0d we=%0d rd=%h ft=%b want 3 1 0 0", lat, wc, rd, ft);
    end
    preload(4'd4, 32'h8081_7F02);
    do_req(1'b1, 3'b001, 32'h10, 32'h1234_5678, rd, ft, lat, wc);
    checks++;
    if (tb_mem[4] !== 32'h8081_5678 || lat != 3 || wc != 1) begin
      errors++;
      $display("FAIL sh: mem=%h lat=%0d we=%0d want 80815678 3 1", tb_mem[4], lat, wc);
    end
    do_req(1'b1, 3'b010, 32'h14, 32'hDEAD_BEEF, rd, ft, lat, wc);
    checks++;
    if (tb_mem[5] !== 32'hDEAD_BEEF || lat != 2 || wc != 1 || ft !== 1'b0) begin
      errors++;
      $display("FAIL sw: mem=%h lat=%0d we=%0d ft=%b want deadbeef 2 1 0", tb_mem[5], lat, wc, ft);
    end
    checks++;
    if (tb_mem[4] !== 32'h8081_5678) begin
      errors++;
      $display("FAIL sw_neighbour: got %h want 80815678", tb_mem[4]);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic ft; int lat; int wc;
    do_req(1'b0, 3'b010, 32'h12, 32'h0, rd, ft, lat, wc);
    checks++;
`ifdef LSU_MISALIGN_TRAP_EN
    if (ft !== 1'b1 || rd !== 32'h0 || lat != 1 || wc != 0) begin
      errors++;
      $display("FAIL lw_misalign: ft=%b rd=%h lat=%0d want 1 0 1", ft, rd, lat);
    end
`else
    if (ft !== 1'b0 || rd !== 32'h8081_5678 || lat != 2 || wc != 0) begin
      errors++;
      $display("FAIL lw_misalign: ft=%b rd=%h lat=%0d want 0 80815678 2", ft, rd, lat);
    end
`endif
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic ft; int lat; int wc;
    do_req(1'b0, 3'b011, 32'h10, 32'h0, rd, ft, lat, wc);
    checks++;
    if (ft !== 1'b1 || rd !== 32'h0 || lat != 1 || wc != 0) begin
      errors++;
      $display("FAIL illegal_load: ft=%b rd=%h lat=%0d we=%0d want 1 0 1 0", ft, rd, lat, wc);
    end
    do_req(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, rd, ft, lat, wc);
    checks++;
    if (ft !== 1'b1 || wc != 0 || tb_mem[4] !== 32'h8081_5678) begin
      errors++;
      $display("FAIL illegal_store: ft=%b we=%0d mem=%h want 1 0 80815678", ft, wc, tb_mem[4]);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic ft; int lat; int wc;
    do_req(1'b0, 3'b010, 32'h14, 32'h0, rd, ft, lat, wc);
    checks++;
    if (rd !== 32'hDEAD_BEEF || resp_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL pre_abort_lw: got %h want deadbeef", rd);
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h10; req_wdata = 32'h0000_00EE;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || resp_valid !== 1'b0 ||
        resp_rdata !== 32'h0 || resp_fault !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: we=%b addr=%h wd=%h v=%b rd=%h f=%b rdy=%b want zeros",
               mem_we, mem_addr, mem_wdata, resp_valid, resp_rdata, resp_fault, req_ready);
    end
    @(negedge clk);
    checks++;
    if (tb_mem[4] !== 32'h8081_5678) begin
      errors++;
      $display("FAIL abort_mem: got %h want 80815678", tb_mem[4]);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready: got %b want 1", req_ready);
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, ft, lat, wc);
    checks++;
    if (rd !== 32'h8081_5678 || ft !== 1'b0 || lat != 2) begin
      errors++;
      $display("FAIL post_abort_lw: rd=%h ft=%b lat=%0d want 80815678 0 2", rd, ft, lat);
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    pre_en = 1'b0; pre_idx = 4'd0; pre_data = 32'h0;
    for (int i = 0; i < 16; i++) tb_mem[i] = 32'h0;
    test_reset();
    test_loads();
    test_stores();
    test_misalign();
    test_illegal();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
